// File: rtl/regfile_writeback_unit.sv
// regfile_writeback_unit
//   Registered writeback stage in front of the single GPR RegFile write port.
//   The pipeline result (link address, formatted load, LO/HI, or ALU result)
//   is registered onto we/W/Din one cycle after in_valid. Results from the
//   multi-cycle mul/div unit arrive on a second, independent channel. They
//   are parked in a small FIFO and are drained onto the write port in cycles
//   where the pipeline is not writing.
//
// Ports
//   clk, rst            clock, synchronous active-high reset
//   in_valid            pipeline writeback request this cycle
//   rs, rt, rd          instruction register fields
//   alu_out, mem_out,
//   lo, hi, pc          candidate write data (pc is the link address)
//   addr_byte           low address bits of a load
//   Jal, RegDst,
//   MemToReg, ExtrSigned,
//   ExtrWord, LHToReg   result selection / load formatting controls
//   md_valid, md_ready,
//   md_dest, md_data    mul/div result channel into the FIFO
//   IR1, IR2            RegFile read indices (rs, rt)
//   we, W, Din          registered RegFile write port
//   pend1, pend2        a queued or issuing write targets IR1 / IR2
//   stall_out           pipeline must keep in_valid low next cycle
//   queue_count         FIFO occupancy
//
// Handshake (md channel): an entry is accepted on a rising clk edge where
// md_valid and md_ready are both high. md_ready depends only on rst and the
// registered occupancy, so it never depends on md_valid or on a same-cycle
// pop; the producer holds md_dest/md_data stable until it sees acceptance.
module regfile_writeback_unit #(
  parameter int DATA_BITS     = 32,
  parameter int REG_ADDR_BITS = 5,
  parameter int LINK_REG      = 31,
  parameter int QUEUE_DEPTH   = 4,
  parameter int STARVE_LIMIT  = 8
) (
  input  logic                             clk,
  input  logic                             rst,
  input  logic                             in_valid,
  input  logic [REG_ADDR_BITS-1:0]         rs,
  input  logic [REG_ADDR_BITS-1:0]         rt,
  input  logic [REG_ADDR_BITS-1:0]         rd,
  input  logic [DATA_BITS-1:0]             alu_out,
  input  logic [DATA_BITS-1:0]             mem_out,
  input  logic [DATA_BITS-1:0]             lo,
  input  logic [DATA_BITS-1:0]             hi,
  input  logic [DATA_BITS-1:0]             pc,
  input  logic [1:0]                       addr_byte,
  input  logic                             Jal,
  input  logic                             RegDst,
  input  logic                             MemToReg,
  input  logic                             ExtrSigned,
  input  logic [1:0]                       ExtrWord,
  input  logic [1:0]                       LHToReg,
  input  logic                             md_valid,
  output logic                             md_ready,
  input  logic [REG_ADDR_BITS-1:0]         md_dest,
  input  logic [DATA_BITS-1:0]             md_data,
  output logic [REG_ADDR_BITS-1:0]         IR1,
  output logic [REG_ADDR_BITS-1:0]         IR2,
  output logic                             we,
  output logic [REG_ADDR_BITS-1:0]         W,
  output logic [DATA_BITS-1:0]             Din,
  output logic                             pend1,
  output logic                             pend2,
  output logic                             stall_out,
  output logic [$clog2(QUEUE_DEPTH):0]     queue_count
);

  localparam int PTR_BITS = $clog2(QUEUE_DEPTH);
  localparam int CNT_BITS = PTR_BITS + 1;
  localparam int AGE_BITS = $clog2(STARVE_LIMIT) + 1;
  // Byte lanes 2/3 are addressable even for a 16-bit datapath; widen the
  // load word so lane selection is always in range (extra lanes read 0).
  localparam int EXT_BITS = (DATA_BITS < 32) ? 32 : DATA_BITS;

  // ---------------------------------------------------------------------
  // Pipeline result selection
  // ---------------------------------------------------------------------
  logic [EXT_BITS-1:0]      mem_ext;
  logic [7:0]               lane_byte;
  logic [15:0]              lane_half;
  logic [DATA_BITS-1:0]     load_val;
  logic [DATA_BITS-1:0]     lh_val;
  logic [REG_ADDR_BITS-1:0] pipe_w;
  logic [DATA_BITS-1:0]     pipe_din;

  assign mem_ext   = EXT_BITS'(mem_out);
  assign lane_byte = mem_ext[{addr_byte, 3'b000} +: 8];
  // Halfword lane uses addr_byte[1] only; an odd address is not trapped here.
  assign lane_half = mem_ext[{addr_byte[1], 4'b0000} +: 16];

  always_comb begin
    load_val = '0;
    case (ExtrWord)
      2'd0: load_val = mem_out;
      2'd1: load_val = ExtrSigned ? {{(DATA_BITS-8){lane_byte[7]}}, lane_byte}
                                  : {{(DATA_BITS-8){1'b0}}, lane_byte};
      2'd2: load_val = ExtrSigned ? {{(DATA_BITS-16){lane_half[15]}}, lane_half}
                                  : {{(DATA_BITS-16){1'b0}}, lane_half};
      default: load_val = '0;
    endcase
  end

  always_comb begin
    lh_val = '0;
    case (LHToReg)
      2'd1:    lh_val = lo;
      2'd2:    lh_val = hi;
      default: lh_val = '0;
    endcase
  end

  always_comb begin
    pipe_w   = RegDst ? rd : rt;
    pipe_din = alu_out;
    if (Jal) begin
      pipe_w   = REG_ADDR_BITS'(LINK_REG);
      pipe_din = pc;
    end else if (MemToReg) begin
      pipe_din = load_val;
    end else if (LHToReg != 2'd0) begin
      pipe_din = lh_val;
    end
  end

  // ---------------------------------------------------------------------
  // mul/div result FIFO
  // ---------------------------------------------------------------------
  logic [REG_ADDR_BITS-1:0] q_dest [QUEUE_DEPTH];
  logic [DATA_BITS-1:0]     q_data [QUEUE_DEPTH];
  logic [PTR_BITS-1:0]      rd_ptr;
  logic [PTR_BITS-1:0]      wr_ptr;
  logic [CNT_BITS-1:0]      count;
  logic [CNT_BITS-1:0]      count_nxt;
  logic [AGE_BITS-1:0]      age;
  logic [AGE_BITS-1:0]      age_nxt;
  logic                     push;
  logic                     pop;

  assign md_ready    = !rst && (count < CNT_BITS'(QUEUE_DEPTH));
  assign push        = md_valid && md_ready;
  // The pipeline owns the write port whenever it has a request.
  assign pop         = !in_valid && (count != '0);
  assign queue_count = count;

  always_comb begin
    count_nxt = count;
    if (push && !pop)      count_nxt = count + 1'b1;
    else if (pop && !push) count_nxt = count - 1'b1;
  end

  // Age of the current head: restarts whenever the head changes (pop) or
  // there is no head; saturates so it cannot wrap back below the limit.
  always_comb begin
    age_nxt = age;
    if (count == '0 || pop)                    age_nxt = '0;
    else if (age < AGE_BITS'(STARVE_LIMIT))    age_nxt = age + 1'b1;
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      rd_ptr    <= '0;
      wr_ptr    <= '0;
      count     <= '0;
      age       <= '0;
      stall_out <= 1'b0;
    end else begin
      if (push) wr_ptr <= wr_ptr + 1'b1;
      if (pop)  rd_ptr <= rd_ptr + 1'b1;
      count     <= count_nxt;
      age       <= age_nxt;
      // Computed from next-state values so stall_out lines up with the
      // occupancy and head age it describes.
      stall_out <= (count_nxt == CNT_BITS'(QUEUE_DEPTH)) ||
                   (age_nxt >= AGE_BITS'(STARVE_LIMIT - 1));
    end
  end

  // Entry storage needs no reset: validity is tracked by count/rd_ptr.
  always_ff @(posedge clk) begin
    if (push) begin
      q_dest[wr_ptr] <= md_dest;
      q_data[wr_ptr] <= md_data;
    end
  end

  // ---------------------------------------------------------------------
  // Registered write port
  // ---------------------------------------------------------------------
  always_ff @(posedge clk) begin
    if (rst) begin
      we  <= 1'b0;
      W   <= '0;
      Din <= '0;
    end else if (in_valid) begin
      we  <= (pipe_w != '0);
      W   <= pipe_w;
      Din <= pipe_din;
    end else if (pop) begin
      // A GPR 0 entry is consumed but never written.
      we  <= (q_dest[rd_ptr] != '0);
      W   <= q_dest[rd_ptr];
      Din <= q_data[rd_ptr];
    end else begin
      we  <= 1'b0;
    end
  end

  // ---------------------------------------------------------------------
  // Read indices and pending-write detection for hazard logic
  // ---------------------------------------------------------------------
  logic q_hit1;
  logic q_hit2;

  assign IR1 = rs;
  assign IR2 = rt;

  always_comb begin
    q_hit1 = 1'b0;
    q_hit2 = 1'b0;
    for (int i = 0; i < QUEUE_DEPTH; i++) begin
      if (CNT_BITS'(i) < count) begin
        if (q_dest[rd_ptr + PTR_BITS'(i)] == rs) q_hit1 = 1'b1;
        if (q_dest[rd_ptr + PTR_BITS'(i)] == rt) q_hit2 = 1'b1;
      end
    end
  end

  assign pend1 = (rs != '0) && (q_hit1 || (we && (W == rs)));
  assign pend2 = (rt != '0) && (q_hit2 || (we && (W == rt)));

endmodule
